// File: rtl/timer_setter_pkg.sv
// Shared widths, limits and wrap helpers for the remind-time fields.
// The display and reminder logic reuse these so the ranges live in one place.
package timer_setter_pkg;

    localparam int HOURS_W   = 5;
    localparam int MINUTES_W = 6;

    typedef logic [HOURS_W-1:0]   hours_t;
    typedef logic [MINUTES_W-1:0] minutes_t;

    localparam hours_t   HOURS_MAX   = 5'd23;
    localparam minutes_t MINUTES_MAX = 6'd59;

    // Next hour value, wrapping 23 -> 0.
    function automatic hours_t hours_inc(input hours_t h);
        return (h >= HOURS_MAX) ? '0 : h + 1'b1;
    endfunction

    // Next minute value, wrapping 59 -> 0 with no carry into hours.
    function automatic minutes_t minutes_inc(input minutes_t m);
        return (m >= MINUTES_MAX) ? '0 : m + 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-flop synchroniser, level debouncer and
// rising-edge detector.  Emits one single-cycle pulse per accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic pressed
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;

    // Debounce next-state: count cycles where the synchronised key disagrees
    // with the accepted level; accept once the count has run the full
    // DEBOUNCE_CYCLES, so a clean press reaches the edge detector
    // DEBOUNCE_CYCLES+2 edges after the first raw high sample.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, counter, accepted level and its one-cycle-delayed copy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values; blocking here would collapse the
        // synchroniser into a single stage.
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= key_in;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    // Only the 0->1 transition of the accepted level counts; holding the key
    // keeps level_q high and produces no further pulses.
    assign pressed = level_q & ~level_prev_q;

endmodule

// File: rtl/timer_setter.sv
// Remind-time editor: each debounced press of increase_key advances the
// selected field (hours or minutes) while editing is enabled and shown.
module timer_setter
    import timer_setter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RESET_HOURS     = 10,
    parameter int RESET_MINUTES   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_mode,
    input  logic                 set_select,
    input  logic                 increase_key,
    input  logic                 visible,
    output logic [HOURS_W-1:0]   hours,
    output logic [MINUTES_W-1:0] minutes
);

    localparam hours_t   HOURS_INIT   = hours_t'(RESET_HOURS);
    localparam minutes_t MINUTES_INIT = minutes_t'(RESET_MINUTES);

    logic     press_pulse;
    logic     edit_en;
    hours_t   hours_q;
    hours_t   hours_d;
    minutes_t minutes_q;
    minutes_t minutes_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk    (clk),
        .reset  (reset),
        .key_in (increase_key),
        .pressed(press_pulse)
    );

    // A pulse arriving while editing is disabled or hidden is simply dropped.
    assign edit_en = press_pulse & set_mode & visible;

    // Increment the selected field with wrap; the other field holds.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        if (edit_en) begin
            if (set_select) begin
                hours_d = hours_inc(hours_q);
            end else begin
                minutes_d = minutes_inc(minutes_q);
            end
        end
    end

    // Remind-time registers; reset wins over a same-edge press.
    always_ff @(posedge clk) begin
        if (reset) begin
            hours_q   <= HOURS_INIT;
            minutes_q <= MINUTES_INIT;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
        end
    end

    assign hours   = hours_q;
    assign minutes = minutes_q;

endmodule

// File: tb/tb_timer_setter.sv
// Scoreboard bench for timer_setter with DEBOUNCE_CYCLES=4.  Stimulus pushes
// the expected {hours, minutes, update edge} whenever it expects an output
// change; the monitor pops and compares on every observed change.
module tb_timer_setter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       set_mode;
    logic       set_select;
    logic       increase_key;
    logic       visible;
    logic [4:0] hours;
    logic [5:0] minutes;

    timer_setter #(
        .DEBOUNCE_CYCLES(N),
        .RESET_HOURS    (10),
        .RESET_MINUTES  (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .set_mode    (set_mode),
        .set_select  (set_select),
        .increase_key(increase_key),
        .visible     (visible),
        .hours       (hours),
        .minutes     (minutes)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge (first edge is 1).
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int h;
        int m;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mh;
    int   mm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: any change on the outputs must match the head of the queue,
    // both in value and in the edge at which it appeared.
    logic [10:0] last_seen = 'x;
    always @(negedge clk) begin : monitor
        logic [10:0] cur;
        exp_t        e;
        cur = {hours, minutes};
        if (cur !== last_seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", 32'(cur), 32'(last_seen));
            end else begin
                e = exp_q.pop_front();
                check("hours_value", 32'(hours), e.h);
                check("minutes_value", 32'(minutes), e.m);
                check("update_edge", edge_cnt, e.edge_no);
            end
            last_seen = cur;
        end
    end

    // Reference model of one accepted edit.
    task automatic model_inc();
        if (set_select) mh = (mh == 23) ? 0 : mh + 1;
        else            mm = (mm == 59) ? 0 : mm + 1;
    endtask

    // Clean press held for 'hold' samples, then released and re-debounced.
    task automatic press(input int hold, input bit expect_inc);
        @(negedge clk);
        increase_key = 1'b1;
        if (expect_inc) begin
            model_inc();
            exp_q.push_back('{mh, mm, edge_cnt + 1 + N + 3});
        end
        repeat (hold) @(negedge clk);
        increase_key = 1'b0;
        repeat (N + 6) @(negedge clk);
    endtask

    // Bounded wait for all expected updates, then confirm the settled value.
    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check({tag, "_pending"}, exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
        check({tag, "_hours"}, 32'(hours), mh);
        check({tag, "_minutes"}, 32'(minutes), mm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        set_mode     = 1'b0;
        set_select   = 1'b0;
        increase_key = 1'b0;
        visible      = 1'b0;
        mh = 10;
        mm = 0;
        exp_q.push_back('{10, 0, 1});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drain("reset");

        // Hours edit; a 50-cycle hold must give exactly one increment.
        set_mode   = 1'b1;
        visible    = 1'b1;
        set_select = 1'b1;
        press(50, 1'b1);
        drain("hours_edit");

        // Walk hours to 23, then wrap to 0.
        while (mh != 23) press(8, 1'b1);
        press(8, 1'b1);
        drain("hours_wrap");

        // Minutes 0 -> 59 -> 0 with hours untouched.
        set_select = 1'b0;
        repeat (60) press(8, 1'b1);
        drain("minutes_wrap");

        // Bounce: 2 high, 1 low, 2 high -> never accepted.
        @(negedge clk);
        increase_key = 1'b1;
        repeat (2) @(negedge clk);
        increase_key = 1'b0;
        @(negedge clk);
        increase_key = 1'b1;
        repeat (2) @(negedge clk);
        increase_key = 1'b0;
        repeat (N + 8) @(negedge clk);
        drain("bounce");

        // Gating: set_mode low, then visible low -> pulses discarded.
        set_mode = 1'b0;
        press(10, 1'b0);
        drain("gate_mode");
        set_mode = 1'b1;
        visible  = 1'b0;
        press(10, 1'b0);
        drain("gate_visible");

        // Key held across set_mode rising: no queued increment.
        visible  = 1'b1;
        set_mode = 1'b0;
        @(negedge clk);
        increase_key = 1'b1;
        repeat (12) @(negedge clk);
        set_mode = 1'b1;
        repeat (10) @(negedge clk);
        increase_key = 1'b0;
        repeat (N + 6) @(negedge clk);
        drain("gate_hold");

        // Reset sampled at edge 3 of a held press, key kept held afterwards.
        set_select = 1'b1;
        @(negedge clk);
        increase_key = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mh = 10;
        mm = 0;
        exp_q.push_back('{mh, mm, edge_cnt + 1});
        @(negedge clk);
        reset = 1'b0;
        model_inc();
        exp_q.push_back('{mh, mm, edge_cnt + 1 + N + 3});
        repeat (20) @(negedge clk);
        increase_key = 1'b0;
        repeat (N + 6) @(negedge clk);
        drain("reset_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_setter.md
TIMER_SETTER -- requirements
Module: timer_setter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive cycles a changed key level must persist before it is accepted.
REQ-002 SHALL have parameter RESET_HOURS, default 10: value loaded into hours on reset.
REQ-003 SHALL have parameter RESET_MINUTES, default 0: value loaded into minutes on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port set_mode, input, 1 bit: 1 enables editing of the remind time.
REQ-007 SHALL have port set_select, input, 1 bit: edit target; 0 selects minutes, 1 selects hours.
REQ-008 SHALL have port increase_key, input, 1 bit: raw, asynchronous, bouncing push-button; 1 means pressed.
REQ-009 SHALL have port visible, input, 1 bit: 1 means the remind time is currently shown; edits are accepted only while it is 1.
REQ-010 SHALL have port hours, output, 5 bits: registered remind hours, range 0-23.
REQ-011 SHALL have port minutes, output, 6 bits: registered remind minutes, range 0-59.

Function
REQ-012 SHALL pass increase_key through a 2-flop synchroniser (s1, s2) before any other use.
REQ-013 SHALL keep a debounce counter that is cleared whenever s2 equals the accepted level.
REQ-014 SHALL set the accepted level to s2 once s2 has differed from it for DEBOUNCE_CYCLES consecutive cycles, then clear the counter.
REQ-015 SHALL restart the debounce count from zero on any glitch shorter than DEBOUNCE_CYCLES, and SHALL not change the accepted level in that case.
REQ-016 SHALL generate a 1-cycle press pulse on each 0->1 transition of the accepted level (accepted level high, previous-cycle copy low).
REQ-017 SHALL produce exactly one pulse per press regardless of hold duration, and SHALL NOT auto-repeat.
REQ-018 SHALL, on an edge where the pulse=1, set_mode=1, visible=1 and set_select=1, update hours to hours+1, wrapping 23->0.
REQ-019 SHALL, on an edge where the pulse=1, set_mode=1, visible=1 and set_select=0, update minutes to minutes+1, wrapping 59->0, with hours unchanged (no carry).
REQ-020 SHALL discard the pulse, not queue it, when set_mode=0 or visible=0 on that edge, leaving the outputs unchanged.
REQ-021 SHALL sample set_select, set_mode and visible on the same edge as the pulse; changes on that edge take effect.
REQ-022 SHALL keep the debouncer running while editing is disabled, so a key held when set_mode rises produces no increment.
REQ-023 SHALL give a latency of exactly DEBOUNCE_CYCLES+3 edges for a clean press, counting from the first edge at which increase_key=1 is sampled to the edge at which the output updates.
REQ-024 SHALL hold both outputs at all other times; hours and minutes are never combinational.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, load hours=RESET_HOURS, minutes=RESET_MINUTES, and clear s1, s2, the counter, the accepted level and the previous-level copy.
REQ-026 SHALL, on reset asserted mid-debounce or mid-press, abort the press with no increment; a key still held after reset releases is reported as a new press once debounced.
REQ-027 SHALL give reset priority over a simultaneous press pulse.

Structure
REQ-028 SHALL place the constants HOURS_MAX=23 and MINUTES_MAX=59 and the field widths (5 and 6 bits) in a shared package for reuse by the display and reminder logic.
REQ-029 SHALL implement the synchroniser, debouncer and edge detect as one sub-module, key_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, key_in, pressed).
REQ-030 SHALL keep the increment/wrap registers in timer_setter itself; no other sub-modules.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 SHALL verify reset: reset=1 for 2 cycles -> hours=10, minutes=0.
REQ-032 SHALL verify hours edit: set_mode=1, visible=1, set_select=1, one clean press -> hours=11 exactly 7 edges after the first high sample; holding 50 cycles gives no further change.
REQ-033 SHALL verify wraps: from hours=23, press -> hours=0; from minutes=59 with set_select=0, press -> minutes=0 and hours unchanged.
REQ-034 SHALL verify bounce rejection: key pulses 2 cycles high, 1 cycle low, then 2 cycles high -> no change.
REQ-035 SHALL verify gating: press with set_mode=0, then a separate press with visible=0 -> outputs unchanged, and no increment after set_mode later returns to 1.
REQ-036 SHALL verify reset mid-operation: key held, reset pulsed at edge 3 of the debounce -> outputs=10:00, then exactly one increment after reset releases with the key still held.
